// File: rtl/alu_iter.sv
// alu_iter: registered integer ALU with one-cycle result and flags.
// Define ALU_ITER_MULDIV_EN to add iterative unsigned MULU/DIVU behind a BUSY state.
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             alu_src,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  input  logic [WIDTH-1:0] imm_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             condition,
  output logic             div0,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_ADDV  = 4'b0101;
  localparam logic [3:0] OP_PASSB = 4'b0110;
  localparam logic [3:0] OP_GTZ   = 4'b0111;
`ifdef ALU_ITER_MULDIV_EN
  localparam logic [3:0] OP_MULU  = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif

  logic [WIDTH-1:0] op_a, op_b, sum, s_res;
  logic             s_ovf, s_cond, s_div0, s_ill, s_lt, accept;

  assign op_a = rs_in;
  assign op_b = alu_src ? imm_in : rt_in;
  assign sum  = op_a + op_b;
  assign s_lt = $signed(op_a) < $signed(op_b);

`ifdef ALU_ITER_MULDIV_EN
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, div_b, nxt_hi, nxt_lo, hi_q, s_hi, diff;
  logic [WIDTH:0]   mul_sum, shifted;
  logic             is_div, start_iter, ge;

  assign in_ready   = (state == IDLE);
  assign hi         = hi_q;
  assign start_iter = (alu_op == OP_MULU) || ((alu_op == OP_DIVU) && (op_b != '0));

  // One shift-add multiply step or one restoring-divide step on {acc_hi, acc_lo}.
  // The partial remainder is always below the divisor, so the subtraction fits in WIDTH bits.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, div_b} : {(WIDTH+1){1'b0}});
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = shifted >= {1'b0, div_b};
    diff    = shifted[WIDTH-1:0] - div_b;
    if (is_div) begin
      nxt_hi = ge ? diff : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end
`else
  assign in_ready = 1'b1;
  assign hi       = '0;
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    s_res  = '0;
    s_ovf  = 1'b0;
    s_cond = 1'b0;
    s_div0 = 1'b0;
    s_ill  = 1'b0;
`ifdef ALU_ITER_MULDIV_EN
    s_hi   = '0;
`endif
    case (alu_op)
      OP_ADD:   s_res = sum;
      OP_SUB:   s_res = op_a - op_b;
      OP_OR:    s_res = op_a | op_b;
      OP_AND:   s_res = op_a & op_b;
      OP_SLT:   s_res = {{(WIDTH-1){1'b0}}, s_lt};
      OP_ADDV: begin
        s_res = sum;
        s_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_PASSB: s_res = op_b;
      OP_GTZ:   s_cond = ~op_a[WIDTH-1] & (op_a != '0);
`ifdef ALU_ITER_MULDIV_EN
      // Only the divide-by-zero case of DIVU completes in one cycle.
      OP_MULU:  s_res = '0;
      OP_DIVU: begin
        s_res  = '1;
        s_hi   = op_a;
        s_div0 = 1'b1;
      end
`endif
      default:  s_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      condition <= 1'b0;
      div0      <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_ITER_MULDIV_EN
      state     <= IDLE;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      div_b     <= '0;
      is_div    <= 1'b0;
      hi_q      <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
`ifdef ALU_ITER_MULDIV_EN
      if (state == BUSY) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt    <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state     <= IDLE;
          out_valid <= 1'b1;
          result    <= nxt_lo;
          hi_q      <= nxt_hi;
          zero      <= (nxt_lo == '0);
          overflow  <= 1'b0;
          condition <= 1'b0;
          div0      <= 1'b0;
          illegal   <= 1'b0;
        end
      end else if (accept && start_iter) begin
        state  <= BUSY;
        cnt    <= CNT_W'(WIDTH);
        acc_hi <= '0;
        acc_lo <= op_a;
        div_b  <= op_b;
        is_div <= (alu_op == OP_DIVU);
      end else
`endif
      if (accept) begin
        out_valid <= 1'b1;
        result    <= s_res;
        zero      <= (s_res == '0);
        overflow  <= s_ovf;
        condition <= s_cond;
        div0      <= s_div0;
        illegal   <= s_ill;
`ifdef ALU_ITER_MULDIV_EN
        hi_q      <= s_hi;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: randomized and directed self-checking bench for alu_iter (WIDTH=32).
// Expectations adapt to whether ALU_ITER_MULDIV_EN is defined for the build.
module tb_alu_iter;

`ifdef ALU_ITER_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        alu_src = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] rs_in = '0, rt_in = '0, imm_in = '0;
  logic        out_valid;
  logic [31:0] result, hi;
  logic        zero, overflow, condition, div0, illegal;

  int checks = 0;
  int failures = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_src(alu_src), .alu_op(alu_op), .rs_in(rs_in), .rt_in(rt_in), .imm_in(imm_in),
    .out_valid(out_valid), .result(result), .hi(hi), .zero(zero), .overflow(overflow),
    .condition(condition), .div0(div0), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic over the operation table; off = edges from accept to out_valid.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, b,
                                output logic [31:0] r, h, output logic [4:0] fl, output int off);
    longint     s;
    logic [63:0] p;
    logic       ovf, cnd, d0, ill;
    r = '0; h = '0; ovf = 0; cnd = 0; d0 = 0; ill = 0; off = 0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a | b;
      4'd3: r = a & b;
      4'd4: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd5: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        ovf = (s > SMAX) || (s < SMIN);
      end
      4'd6: r = b;
      4'd7: cnd = ($signed(a) > 0);
      4'd8: if (MULDIV) begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0]; h = p[63:32]; off = 32;
      end else ill = 1;
      4'd9: if (MULDIV) begin
        if (b == 0) begin r = 32'hFFFF_FFFF; h = a; d0 = 1; end
        else begin r = a / b; h = a % b; off = 32; end
      end else ill = 1;
      default: ill = 1;
    endcase
    fl = {(r == 0), ovf, cnd, d0, ill};
  endfunction

  // Drives one request when in_ready is high and measures the result beat.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, rt, imm, input logic src,
                       output int off, output logic [31:0] r, h, output logic [4:0] fl);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    alu_op = op; rs_in = a; rt_in = rt; imm_in = imm; alu_src = src; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    off = -1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin off = i; break; end
      @(posedge clk); #1;
    end
    r = result; h = hi; fl = {zero, overflow, condition, div0, illegal};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, result, hi, zero, overflow, condition, div0, illegal} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got ov=%b r=%h hi=%h flags=%b exp all 0",
               out_valid, result, hi, {zero, overflow, condition, div0, illegal});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready got %b exp 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic [3:0] op, input logic [31:0] a, b,
                               input logic src);
    logic [31:0] r, h, er, eh, junk;
    logic [4:0]  fl, efl;
    int          off, eoff;
    junk = $urandom;
    model(op, a, b, er, eh, efl, eoff);
    if (src) do_op(op, a, junk, b, src, off, r, h, fl);
    else     do_op(op, a, b, junk, src, off, r, h, fl);
    checks++;
    if (off !== eoff) begin
      failures++; $display("[TB] FAIL %s_latency op=%h got %0d exp %0d", name, op, off, eoff);
    end
    checks++;
    if (r !== er || h !== eh || fl !== efl) begin
      failures++;
      $display("[TB] FAIL %s op=%h a=%h b=%h got r=%h hi=%h fl=%b exp r=%h hi=%h fl=%b",
               name, op, a, b, r, h, fl, er, eh, efl);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  ops[10] = '{4'd4, 4'd4, 4'd5, 4'd0, 4'd7, 4'd7, 4'd1, 4'd6, 4'd15, 4'd3};
    logic [31:0] as[10]  = '{32'hFFFF_FFFB, 32'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                             32'd5, 32'd3, 32'd0, 32'd1, 32'hF0F0_1234};
    logic [31:0] bs[10]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0,
                             32'd0, 32'd5, 32'hABCD_0001, 32'd2, 32'h0FF0_FFFF};
    for (int i = 0; i < 10; i++) run_and_check("directed", ops[i], as[i], bs[i], i[0]);
  endtask

  task automatic test_muldiv();
    run_and_check("mulu_max", 4'd8, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_and_check("divu", 4'd9, 32'd100, 32'd7, 1'b0);
    run_and_check("divu_zero", 4'd9, 32'd9, 32'd0, 1'b1);
    run_and_check("code_1000", 4'd8, 32'd6, 32'd7, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [3:0]  op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = '0;
      run_and_check("random", op, a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, er, eh;
    logic [4:0]  efl;
    int          eoff;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      alu_op = 4'($urandom_range(0, 6)); rs_in = a; rt_in = b; alu_src = 1'b0; in_valid = 1'b1;
      model(alu_op, a, b, er, eh, efl, eoff);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== er) begin
        failures++;
        $display("[TB] FAIL back_to_back beat=%0d got ov=%b r=%h exp ov=1 r=%h", i, out_valid, result, er);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== er) begin
      failures++;
      $display("[TB] FAIL hold_after_pulse got ov=%b r=%h exp ov=0 r=%h", out_valid, result, er);
    end
  endtask

  task automatic test_busy_ignore();
`ifdef ALU_ITER_MULDIV_EN
    int off = -1;
    bit ready_low = 1'b1;
    @(negedge clk);
    alu_op = 4'd8; rs_in = 32'hFFFF_FFFF; rt_in = 32'd2; alu_src = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin off = i; break; end
      if (in_ready) ready_low = 1'b0;
      @(negedge clk);
      if (i == 5) begin alu_op = 4'd0; rs_in = 32'd1; rt_in = 32'd1; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    checks++;
    if (off !== 32 || ready_low !== 1'b1) begin
      failures++; $display("[TB] FAIL busy_window got off=%0d ready_low=%b exp off=32 ready_low=1", off, ready_low);
    end
    checks++;
    if (result !== 32'hFFFF_FFFE || hi !== 32'd1) begin
      failures++; $display("[TB] FAIL busy_result got r=%h hi=%h exp r=fffffffe hi=00000001", result, hi);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL busy_no_ghost got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
    end
`endif
  endtask

  task automatic test_reset_mid_busy();
    int seen = 0;
`ifdef ALU_ITER_MULDIV_EN
    @(negedge clk);
    alu_op = 4'd8; rs_in = 32'h1234_5678; rt_in = 32'h9ABC_DEF1; alu_src = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, result, hi, zero, overflow, condition, div0, illegal} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_busy got ov=%b r=%h hi=%h rdy=%b exp zeros rdy=1",
               out_valid, result, hi, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++;
    if (seen !== 0) begin
      failures++; $display("[TB] FAIL aborted_no_valid got %0d pulses exp 0", seen);
    end
    run_and_check("add_after_reset", 4'd0, 32'd3, 32'd4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_muldiv();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised successor to the single-cycle CPU ALU for the multicycle datapath. It executes the existing integer ops at configurable width with a registered one-cycle result. It adds iterative unsigned multiply/divide behind a valid/ready handshake, corrects the signed set-less-than, and registers all flags alongside the result.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 4, even.
- `CNT_W`, `$clog2(WIDTH)+1`: iteration counter width.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept; `in_ready = (state == IDLE)`.
- `alu_src` in 1: 0 = operand B is `rt_in`, 1 = operand B is `imm_in`.
- `alu_op` in 4: operation select (see Operation).
- `rs_in`, `rt_in`, `imm_in` in WIDTH: operands; `imm_in` is already extended upstream.
- `out_valid` out 1: one-cycle pulse; result and flags are valid.
- `result` out WIDTH: low result, or quotient for divide.
- `hi` out WIDTH: high product or remainder; 0 for other ops.
- `zero` out 1: `result == 0`.
- `overflow` out 1: signed overflow (ADDV only).
- `condition` out 1: branch condition (GTZ only).
- `div0` out 1: divide by zero.
- `illegal` out 1: undefined `alu_op`.

## Operation
- Let A = `rs_in` and B = `rt_in` or `imm_in`, selected by `alu_src`. Operands are captured on accept (`in_valid & in_ready`).
- `0000` ADD: A+B, mod 2^WIDTH.
- `0001` SUB: A−B.
- `0010` OR.
- `0011` AND.
- `0100` SLT: 1 if signed A < signed B, else 0. This holds for every sign combination, including both negative.
- `0101` ADDV: A+B with `overflow = (A[msb]==B[msb]) & (sum[msb]!=A[msb])`.
- `0110` PASSB: result = B.
- `0111` GTZ: `condition = ~A[msb] & (A != 0)`; result = 0.
- `1000` MULU: unsigned A×B; `{hi,result}` = 2·WIDTH-bit product; shift-add, one bit per cycle.
- `1001` DIVU: unsigned restoring division, one bit per cycle. result = quotient, hi = remainder.
  - If B = 0: skip iteration; result = all ones, hi = A, `div0` = 1.
- Any other code: result = 0, `illegal` = 1, latency 1.
- FSM states:
  - IDLE: on accept of a single-cycle op, stay in IDLE. On MULU/DIVU (B≠0), go to BUSY with counter = WIDTH.
  - BUSY: one iteration per edge, counter decrements. When it reaches 0, go to IDLE and pulse `out_valid`.
- Flags not relevant to the op are 0 in that result beat. `zero` is evaluated on `result` only.

## Timing
- Reset: `in_ready` = 1 (state IDLE). `out_valid`, `result`, `hi`, and all flags = 0. Counter = 0.
- Single-cycle ops and DIVU-by-zero: accept at edge k, `out_valid` high for cycle k→k+1.
  - Back-to-back accepts every cycle are allowed, giving one result per cycle.
- MULU/DIVU: accept at edge k, `in_ready` low from k to k+WIDTH, result registered and `out_valid` pulsed at edge k+WIDTH.
  - Earliest next accept is edge k+WIDTH+1.
- `in_valid` while `in_ready` = 0 is ignored. The requester holds the request; no queueing.
- `out_valid` is not back-pressured. Consumers sample it in its single cycle.
- Outputs hold their last value between pulses. Only `out_valid` returns to 0.
- `rst` mid-BUSY: the operation is aborted with no `out_valid`. Next cycle all outputs are 0 and `in_ready` = 1.
- `rst` has priority over a simultaneous accept.

## Configuration
- `ALU_ITER_MULDIV_EN` defined: MULU/DIVU, the BUSY state and the iteration datapath are compiled in.
- Not defined: codes `1000`/`1001` behave as undefined codes (result 0, `illegal` = 1, latency 1). `hi` is tied to 0, `in_ready` is constantly 1, and no multi-cycle state exists.

## Test plan
- SLT, WIDTH=32: A=0xFFFFFFFB (−5), B=0xFFFFFFFD (−3) → result 1. A=1, B=0xFFFFFFFF → 0. Each `out_valid` arrives exactly 1 cycle after accept.
- ADDV: 0x7FFFFFFF+1 → result 0x80000000, overflow 1, zero 0. ADD 0xFFFFFFFF+1 → result 0, zero 1, overflow 0. GTZ A=0 → condition 0; A=5 → 1.
- MULU (macro on): 0xFFFFFFFF×2 → hi=1, result=0xFFFFFFFE. `out_valid` asserts 32 cycles after accept. `in_ready` is low throughout, and an `in_valid` pulse during that window is ignored.
- DIVU: 100/7 → result 14, hi 2, latency 32. 9/0 → result 0xFFFFFFFF, hi 9, div0 1, latency 1.
- Reset in cycle 10 of MULU → no `out_valid`, all outputs 0, `in_ready` = 1 the following cycle. A subsequent ADD 3+4 → 7 after 1 cycle.
- Macro off: `alu_op` 1000 → result 0, illegal 1, latency 1. `alu_op` 1111 gives the same in both builds.
